// File: rtl/ibuf_feeder.sv
// ibuf_feeder: feeds 4-word tiles from an input stream into the input-buffer columns and sequences array calc bursts per job.
//   CLK, RSTN            clock (rising edge), asynchronous active-low reset
//   CMD_VALID/READY      job command handshake; CMD_NTILE tiles per job, CMD_ODST job tag
//   IN_VALID/READY       input word handshake; IN_DATA packed 4x8-bit activation word
//   LOAD_EN, IDST, IWord input-buffer column write strobe, column index, write data
//   START_CALC           column-0 shift enable, high 4 cycles per tile
//   ODST                 latched job tag, held until the next accepted command
//   BUSY, DONE           not-idle flag, one-cycle job completion pulse
//   DRAIN_CYC must be at least 1.
module ibuf_feeder #(
  parameter int DRAIN_CYC = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_NTILE,
  input  logic [3:0]  CMD_ODST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic        LOAD_EN,
  output logic [1:0]  IDST,
  output logic [31:0] IWord,
  output logic        START_CALC,
  output logic [3:0]  ODST,
  output logic        BUSY,
  output logic        DONE
);
  typedef enum logic [2:0] {IDLE, LOAD, GAP, CALC, DRAIN, FIN} state_t;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);
  state_t state, nxt;
  logic [7:0] tile_cnt, cnt;
  logic [1:0] widx;
  logic cmd_hs, in_hs, calc_end, drain_end;
  logic cmd_ready_d, in_ready_d, start_calc_d, busy_d, done_d;
  assign cmd_hs    = CMD_VALID & CMD_READY;
  assign in_hs     = IN_VALID & IN_READY;
  assign calc_end  = state == CALC && cnt == 8'd3;
  assign drain_end = state == DRAIN && cnt == DRAIN_LAST;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cmd_hs ? (CMD_NTILE != 8'd0 ? LOAD : FIN) : IDLE;
      LOAD:    nxt = in_hs && widx == 2'd3 ? GAP : LOAD;
      GAP:     nxt = CALC;
      CALC:    nxt = calc_end ? DRAIN : CALC;
      DRAIN:   nxt = drain_end ? (tile_cnt == 8'd1 ? FIN : LOAD) : DRAIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Phase counter runs only while staying in CALC or DRAIN, so it is 0 on entry to either.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      tile_cnt <= '0;
      widx     <= '0;
      cnt      <= '0;
    end else begin
      tile_cnt <= cmd_hs ? CMD_NTILE : drain_end ? tile_cnt - 8'd1 : tile_cnt;
      widx     <= cmd_hs ? 2'd0 : in_hs ? widx + 2'd1 : widx;
      cnt      <= state == nxt && (state == CALC || state == DRAIN) ? cnt + 8'd1 : 8'd0;
    end
  // Outputs are registered from the next state so they line up with the state they describe;
  // DONE is registered from FIN itself, landing in the first IDLE cycle.
  always_comb begin
    cmd_ready_d  = nxt == IDLE;
    in_ready_d   = nxt == LOAD;
    start_calc_d = nxt == CALC;
    busy_d       = nxt != IDLE;
    done_d       = state == FIN;
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      CMD_READY  <= 1'b0;
      IN_READY   <= 1'b0;
      START_CALC <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      LOAD_EN    <= 1'b0;
      IDST       <= '0;
      IWord      <= '0;
      ODST       <= '0;
    end else begin
      CMD_READY  <= cmd_ready_d;
      IN_READY   <= in_ready_d;
      START_CALC <= start_calc_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      LOAD_EN    <= in_hs;
      IDST       <= in_hs ? widx : IDST;
      IWord      <= in_hs ? IN_DATA : IWord;
      ODST       <= cmd_hs ? CMD_ODST : ODST;
    end
endmodule

// File: tb/tb_ibuf_feeder.sv
// tb_ibuf_feeder: directed and randomized jobs against a cycle-schedule reference model of ibuf_feeder.
module tb_ibuf_feeder;
  localparam int D = 3;
  localparam int N = 16384;
  logic CLK = 0, RSTN = 1, CMD_VALID = 0, IN_VALID = 0;
  logic CMD_READY, IN_READY, LOAD_EN, START_CALC, BUSY, DONE;
  logic [7:0] CMD_NTILE = 0;
  logic [3:0] CMD_ODST = 0, ODST;
  logic [31:0] IN_DATA = 0, IWord;
  logic [1:0] IDST;
  always #5 CLK = ~CLK;
  ibuf_feeder #(.DRAIN_CYC(D)) dut (
    .CLK(CLK), .RSTN(RSTN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_NTILE(CMD_NTILE), .CMD_ODST(CMD_ODST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .LOAD_EN(LOAD_EN), .IDST(IDST), .IWord(IWord), .START_CALC(START_CALC),
    .ODST(ODST), .BUSY(BUSY), .DONE(DONE)
  );
  typedef struct {logic [7:0] nt; logic [3:0] od;} cmd_t;
  cmd_t cq[$];
  int nchk = 0, npass = 0, cyc = 0;
  bit m_le[N], m_sc[N], m_dn[N];
  logic [31:0] m_wd[N];
  logic [1:0] m_id[N];
  bit idle, loading, seq_data;
  int cr_from, bz_to, ir_from, odst_at, tiles, k, in_mode, seq_i;
  logic [3:0] e_odst, odst_nx;
  logic [31:0] e_word;
  logic [1:0] e_idst;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
  endtask
  task automatic check_zero(input string t);
    chk({t, "_cmd_ready"}, CMD_READY, 0);
    chk({t, "_in_ready"}, IN_READY, 0);
    chk({t, "_load_en"}, LOAD_EN, 0);
    chk({t, "_start_calc"}, START_CALC, 0);
    chk({t, "_done"}, DONE, 0);
    chk({t, "_busy"}, BUSY, 0);
    chk({t, "_idst"}, IDST, 0);
    chk({t, "_iword"}, IWord, 0);
    chk({t, "_odst"}, ODST, 0);
  endtask
  task automatic push(input logic [7:0] nt, input logic [3:0] od);
    cmd_t c;
    c.nt = nt;
    c.od = od;
    cq.push_back(c);
  endtask
  task automatic end_job(input int e);
    idle = 1;
    cr_from = e;
    bz_to = e;
    m_dn[e] = 1;
  endtask
  task automatic do_reset();
    RSTN = 0;
    CMD_VALID = 0;
    IN_VALID = 0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < N; i++) begin
      m_le[i] = 0;
      m_sc[i] = 0;
      m_dn[i] = 0;
    end
    idle = 1; loading = 0; bz_to = 0; odst_at = -1; k = 0; tiles = 0;
    e_odst = 0; e_word = 0; e_idst = 0;
    @(posedge CLK);
    cyc++;
    #1;
    check_zero("rst_hold");
    RSTN = 1;
    cr_from = cyc + 1;
  endtask
  task automatic tick();
    bit ecr, eir, ebz;
    @(posedge CLK);
    cyc++;
    #1;
    if (cyc == odst_at) e_odst = odst_nx;
    if (m_le[cyc]) begin
      e_word = m_wd[cyc];
      e_idst = m_id[cyc];
    end
    ecr = idle && cyc >= cr_from;
    eir = loading && cyc >= ir_from;
    ebz = !idle || cyc < bz_to;
    chk("cmd_ready", CMD_READY, ecr);
    chk("in_ready", IN_READY, eir);
    chk("busy", BUSY, ebz);
    chk("load_en", LOAD_EN, m_le[cyc]);
    chk("start_calc", START_CALC, m_sc[cyc]);
    chk("done", DONE, m_dn[cyc]);
    chk("idst", IDST, e_idst);
    chk("iword", IWord, e_word);
    chk("odst", ODST, e_odst);
    CMD_VALID = cq.size() > 0;
    if (CMD_VALID) begin
      CMD_NTILE = cq[0].nt;
      CMD_ODST = cq[0].od;
    end
    IN_VALID = in_mode == 0 ? 1'b1 : in_mode == 1 ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
    IN_DATA = seq_data ? 32'h11223344 + 32'h11111111 * 32'(seq_i) : $urandom;
    if (CMD_VALID && ecr) begin
      cmd_t c;
      c = cq.pop_front();
      idle = 0;
      odst_at = cyc + 1;
      odst_nx = c.od;
      if (c.nt == 0) end_job(cyc + 2);
      else begin
        tiles = int'(c.nt);
        loading = 1;
        ir_from = cyc + 1;
        k = 0;
      end
    end
    if (IN_VALID && eir) begin
      m_le[cyc+1] = 1;
      m_wd[cyc+1] = IN_DATA;
      m_id[cyc+1] = 2'(k);
      k++;
      seq_i++;
      if (k == 4) begin
        k = 0;
        loading = 0;
        for (int i = 2; i <= 5; i++) m_sc[cyc+i] = 1;
        tiles--;
        if (tiles > 0) begin
          loading = 1;
          ir_from = cyc + 6 + D;
        end else end_job(cyc + 7 + D);
      end
    end
  endtask
  task automatic run(input int lim);
    int n = 0;
    while (n < lim && !(cq.size() == 0 && idle && cyc >= cr_from)) begin
      tick();
      n++;
    end
    chk("job_timeout", 32'(n < lim), 1);
  endtask
  initial begin
    in_mode = 0; seq_data = 0; seq_i = 0;
    #3;
    do_reset();
    seq_data = 1;
    push(8'd1, 4'd5);
    run(100);
    seq_data = 0;
    repeat (3) tick();
    in_mode = 1;
    push(8'd2, 4'd3);
    run(200);
    in_mode = 0;
    push(8'd0, 4'd7);
    run(20);
    push(8'd1, 4'h5);
    push(8'd1, 4'hA);
    run(200);
    push(8'd1, 4'd2);
    begin
      int n = 0;
      while (n < 100 && k != 2) begin
        tick();
        n++;
      end
      chk("k2_timeout", 32'(n < 100), 1);
    end
    tick();
    do_reset();
    repeat (3) tick();
    push(8'd1, 4'd9);
    run(100);
    in_mode = 2;
    repeat (8) push(8'($urandom_range(0, 3)), 4'($urandom));
    run(2000);
    in_mode = 0;
    push(8'd255, 4'd3);
    run(5000);
    repeat (3) tick();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/ibuf_feeder.md
IBUF_FEEDER -- requirements
Module: ibuf_feeder

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 3: idle cycles after the last START_CALC cycle before the next tile or DONE.
REQ-002 SHALL have CLK  input  1  clock, rising-edge.
REQ-003 SHALL have RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have CMD_VALID  input  1  job command valid.
REQ-005 SHALL have CMD_READY  output  1  job command accepted when CMD_VALID&CMD_READY.
REQ-006 SHALL have CMD_NTILE  input  8  tiles in job (4 words each).
REQ-007 SHALL have CMD_ODST  input  4  output-destination tag for job.
REQ-008 SHALL have IN_VALID  input  1  input word stream valid.
REQ-009 SHALL have IN_READY  output  1  word accepted when IN_VALID&IN_READY.
REQ-010 SHALL have IN_DATA  input  32  packed 4x8-bit activation word.
REQ-011 SHALL have LOAD_EN  output  1  input-buffer column write strobe.
REQ-012 SHALL have IDST  output  2  destination column of the write.
REQ-013 SHALL have IWord  output  32  write data.
REQ-014 SHALL have START_CALC  output  1  column-0 shift enable into the array.
REQ-015 SHALL have ODST  output  4  job tag, forwarded downstream.
REQ-016 SHALL have BUSY  output  1  high whenever state is not IDLE.
REQ-017 SHALL have DONE  output  1  one-cycle pulse at job completion.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, GAP, CALC, DRAIN, FIN; all outputs registered.
REQ-019 IDLE: CMD_READY=1; on CMD_VALID, latch CMD_NTILE into tile counter and CMD_ODST into ODST; go to LOAD (NTILE!=0) or FIN (NTILE==0).
REQ-020 LOAD: IN_READY=1; each handshake in cycle t produces LOAD_EN=1, IWord=IN_DATA, IDST=word index (0,1,2,3) in cycle t+1.
REQ-021 The 2-bit word index SHALL reset to 0 at each tile start and increment only on handshake; no IN_VALID means no LOAD_EN and no index advance.
REQ-022 On the 4th handshake go to GAP; IN_READY SHALL deassert in the cycle after the 4th handshake.
REQ-023 GAP lasts exactly 1 cycle, guaranteeing the last LOAD_EN precedes START_CALC.
REQ-024 CALC: START_CALC=1 for exactly 4 consecutive cycles, first high 2 cycles after the 4th handshake cycle; LOAD_EN=0 throughout.
REQ-025 DRAIN: DRAIN_CYC cycles with START_CALC=0, IN_READY=0; then decrement tile counter; go to LOAD if counter nonzero, else FIN.
REQ-026 FIN: DONE=1 for exactly one cycle; return to IDLE next cycle.
REQ-027 CMD_READY SHALL be 0 in all states except IDLE; a CMD_VALID outside IDLE is ignored and must be held by the sender.
REQ-028 ODST SHALL hold the latched tag from command acceptance until the next accepted command.
REQ-029 CMD_NTILE=255 SHALL process 255 tiles; counter 8-bit, no wrap beyond zero.
REQ-030 IWord and IDST SHALL hold their last value when LOAD_EN=0.

Reset
REQ-031 RSTN low SHALL force state IDLE, counters 0, and LOAD_EN, START_CALC, IN_READY, DONE, IDST, IWord, ODST all 0, with CMD_READY=0 during reset and 1 from the first clock after release.
REQ-032 Reset mid-job SHALL abort immediately: no further LOAD_EN, START_CALC, or DONE until a new command.

Verification
REQ-033 NTILE=1, ODST=5, IN_VALID always high, words 0x11223344..0x44556677 -> LOAD_EN four consecutive cycles, IDST 0,1,2,3, GAP, START_CALC 4 cycles, 3 drain cycles, DONE once, ODST=5 throughout.
REQ-034 NTILE=2 with IN_VALID toggling every other cycle -> exactly 8 LOAD_EN pulses, IDST sequence 0..3 twice, two 4-cycle START_CALC bursts, one DONE.
REQ-035 NTILE=0 -> no IN_READY, no LOAD_EN, no START_CALC; DONE pulse 2 cycles after command handshake.
REQ-036 CMD_VALID asserted during CALC with a new tag -> CMD_READY stays 0, ODST unchanged; new command accepted the cycle after FIN.
REQ-037 RSTN asserted after 2nd word of a tile -> all outputs 0 asynchronously; after release, no LOAD_EN/DONE until next command, which starts at IDST=0.
